// File: rtl/crc32_serial_appender.sv
// Serial CRC-32 generator: forwards frame bits one per beat, then appends the CRC LSB first.
// Optional macro CRC32_TX_FINAL_XOR_EN inverts the appended CRC and crc_value.
module crc32_serial_appender #(
  parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_POLY = 32'h81010008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_bit,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_bit,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [31:0] crc_value,
  output logic        crc_done
);

  localparam int unsigned CRC_W = 32;
  localparam int unsigned CNT_W = 5;

`ifdef CRC32_TX_FINAL_XOR_EN
  localparam logic [CRC_W-1:0] FINAL_XOR = 32'hFFFFFFFF;
`else
  localparam logic [CRC_W-1:0] FINAL_XOR = 32'h00000000;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [CRC_W-1:0]   crc, crc_n;
  logic [CRC_W-1:0]   shift, shift_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               out_bit_n, out_valid_n, out_last_n;
  logic [CRC_W-1:0]   crc_value_n;
  logic               crc_done_n;
  logic               stage_free_c;
  logic               in_accept_c;
  logic               fb_c;
  logic [CRC_W-1:0]   crc_step_c;

  // Output register can take a new beat when empty or being drained this cycle
  assign stage_free_c = !out_valid || out_ready;
  assign in_ready     = (state != CRC) && stage_free_c;
  assign in_accept_c  = in_valid && in_ready;
  assign fb_c         = crc[0] ^ in_bit;
  assign crc_step_c   = (crc >> 1) ^ (fb_c ? CRC_POLY : '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc       <= CRC_INIT;
      shift     <= '0;
      cnt       <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      crc_value <= '0;
      crc_done  <= 1'b0;
    end else begin
      crc       <= crc_n;
      shift     <= shift_n;
      cnt       <= cnt_n;
      out_bit   <= out_bit_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      crc_value <= crc_value_n;
      crc_done  <= crc_done_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    crc_n       = crc;
    shift_n     = shift;
    cnt_n       = cnt;
    out_bit_n   = out_bit;
    out_last_n  = out_last;
    out_valid_n = out_valid && !out_ready;
    crc_value_n = crc_value;
    crc_done_n  = out_valid && out_ready && out_last;

    unique case (state)
      IDLE, DATA: begin
        if (in_accept_c) begin
          out_bit_n   = in_bit;
          out_last_n  = 1'b0;
          out_valid_n = 1'b1;
          if (in_last) begin
            state_n     = CRC;
            shift_n     = crc_step_c ^ FINAL_XOR;
            crc_value_n = crc_step_c ^ FINAL_XOR;
            cnt_n       = '0;
            crc_n       = CRC_INIT;
          end else begin
            state_n = DATA;
            crc_n   = crc_step_c;
          end
        end
      end
      CRC: begin
        if (stage_free_c) begin
          out_bit_n   = shift[0];
          out_valid_n = 1'b1;
          out_last_n  = (cnt == CNT_W'(31));
          shift_n     = shift >> 1;
          cnt_n       = cnt + CNT_W'(1);
          if (cnt == CNT_W'(31)) begin
            state_n = IDLE;
            crc_n   = CRC_INIT;
          end
        end
      end
      default: begin
        state_n = IDLE;
        crc_n   = CRC_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_crc32_serial_appender.sv
// Directed bench for crc32_serial_appender: frame vectors, throttling, back-to-back and mid-frame reset.
module tb_crc32_serial_appender;

  localparam logic [31:0] INIT = 32'hFFFFFFFF;
  localparam logic [31:0] POLY = 32'h81010008;
`ifdef CRC32_TX_FINAL_XOR_EN
  localparam logic [31:0] FX = 32'hFFFFFFFF;
`else
  localparam logic [31:0] FX = 32'h00000000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_bit = 1'b0, in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic        out_bit, out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [31:0] crc_value;
  logic        crc_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected output stream built by add_frame, consumed by run_stream
  logic [127:0] e_bits, e_lasts;
  int           e_len;
  logic [63:0]  s_bits, s_lasts;
  int           s_len;

  crc32_serial_appender dut (
    .clk(clk), .rst(rst),
    .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .crc_value(crc_value), .crc_done(crc_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_model(input logic [63:0] b, input int n);
    logic [31:0] c;
    c = INIT;
    for (int i = 0; i < n; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  task automatic clear_stream();
    e_bits = '0; e_lasts = '0; e_len = 0;
    s_bits = '0; s_lasts = '0; s_len = 0;
  endtask

  // Appends one frame's input beats and its expected data+CRC output beats
  task automatic add_frame(input int n, input logic [63:0] bits, input logic [31:0] crc);
    for (int i = 0; i < n; i++) begin
      s_bits[s_len] = bits[i];
      s_lasts[s_len] = (i == n - 1);
      s_len++;
      e_bits[e_len] = bits[i];
      e_len++;
    end
    for (int i = 0; i < 32; i++) begin
      e_bits[e_len] = crc[i];
      e_lasts[e_len] = (i == 31);
      e_len++;
    end
  endtask

  task automatic run_stream(input string name, input bit throttle, input int exp_dones,
                            input logic [31:0] exp_crc);
    int idx = 0, beats = 0, cyc = 0, dones = 0;
    int bit_errs = 0, last_errs = 0, stall_errs = 0, extra = 0;
    logic p_stall = 1'b0, p_bit = 1'b0, p_last = 1'b0;
    while (beats < e_len && cyc < 4000) begin
      @(negedge clk);
      out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (idx < s_len);
      in_bit    = (idx < s_len) ? s_bits[idx] : 1'b0;
      in_last   = (idx < s_len) ? s_lasts[idx] : 1'b0;
      #1;
      if (crc_done) dones++;
      if (p_stall && (!out_valid || out_bit !== p_bit || out_last !== p_last)) stall_errs++;
      p_stall = out_valid && !out_ready;
      p_bit   = out_bit;
      p_last  = out_last;
      if (out_valid && out_ready) begin
        if (out_bit !== e_bits[beats]) bit_errs++;
        if (out_last !== e_lasts[beats]) last_errs++;
        beats++;
      end
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      #1;
      if (crc_done) dones++;
      if (out_valid) extra++;
    end
    chk({name, " beats"}, 32'(beats + extra), 32'(e_len));
    chk({name, " inputs consumed"}, 32'(idx), 32'(s_len));
    chk({name, " data/crc bit errors"}, 32'(bit_errs), 32'd0);
    chk({name, " out_last errors"}, 32'(last_errs), 32'd0);
    chk({name, " stall instability"}, 32'(stall_errs), 32'd0);
    chk({name, " crc_done pulses"}, 32'(dones), 32'(exp_dones));
    chk({name, " crc_value"}, crc_value, exp_crc);
    if (!throttle) chk({name, " cycles"}, 32'(cyc), 32'(e_len + 1));
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [63:0] bits;
    logic [31:0] crc;
  } vec_t;

  vec_t vecs[4];
  logic [63:0] long_bits;
  logic [31:0] long_crc;

  initial begin
    vecs[0] = '{"bit0",  1, 64'h0, 32'hFEFEFFF7};
    vecs[1] = '{"bit1",  1, 64'h1, 32'h7FFFFFFF};
    vecs[2] = '{"bits11", 2, 64'h3, 32'h3FFFFFFF};
    vecs[3] = '{"bits00", 2, 64'h0, 32'hFE7E7FF3};

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_bit", 32'(out_bit), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst crc_done", 32'(crc_done), 32'd0);
    chk("rst crc_value", crc_value, 32'h0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      clear_stream();
      add_frame(vecs[i].n, vecs[i].bits, vecs[i].crc ^ FX);
      run_stream(vecs[i].name, 1'b0, 1, vecs[i].crc ^ FX);
    end

    // 64-bit frame, unthrottled then ~50% throttled against the same expected stream
    long_bits = 64'hA5C3_0F1E_7B29_D486;
    long_crc  = crc_model(long_bits, 64) ^ FX;
    clear_stream();
    add_frame(64, long_bits, long_crc);
    run_stream("long", 1'b0, 1, long_crc);
    run_stream("long throttled", 1'b1, 1, long_crc);

    // Back-to-back frames with in_valid held high: second CRC starts from INIT
    clear_stream();
    add_frame(1, 64'h1, 32'h7FFFFFFF ^ FX);
    add_frame(1, 64'h0, 32'hFEFEFFF7 ^ FX);
    run_stream("b2b", 1'b0, 2, 32'hFEFEFFF7 ^ FX);

    // Reset pulsed during the CRC phase
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_bit = 1'b0; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (11) @(negedge clk);
    #1;
    chk("midrst busy in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst crc_value", crc_value, 32'h0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_stream();
    add_frame(1, 64'h0, 32'hFEFEFFF7 ^ FX);
    run_stream("after rst", 1'b0, 1, 32'hFEFEFFF7 ^ FX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
